// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32 MEM stage: one outstanding load/store,
// fixed-latency response with load alignment/extension and misalignment errors.
module dmem_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        stall_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [1:0] LAT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state, state_nxt;
    logic [1:0]        cnt, cnt_nxt;
    logic              accept;
    logic              addr_err;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [31:0]       cap_word;
    logic              cap_we, cap_err, cap_uns;
    logic [1:0]        cap_size, cap_off;

    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;

    // Address bits above the word index alias onto the same array entries.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[31:IDX_W+2];

    assign req_ready_o = (state != BUSY);
    assign stall_o     = req_valid_i && !req_ready_o;
    assign accept      = req_valid_i && req_ready_o;
    assign idx         = req_addr_i[IDX_W+1:2];

    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        addr_err  = 1'b0;
        be        = 4'b0000;
        wdata_rep = req_wdata_i;
        case (req_size_i)
            2'b00: begin
                be        = 4'b0001 << req_addr_i[1:0];
                wdata_rep = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                addr_err  = req_addr_i[0];
                be        = req_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata_i[15:0]}};
            end
            2'b10: begin
                addr_err  = (req_addr_i[1:0] != 2'b00);
                be        = 4'b1111;
            end
            default: addr_err = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = LAT_INIT;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (cnt == 2'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 2'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the array and capture registers are deliberately not reset; outputs are gated by the FSM.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            cap_word <= mem[idx];
            cap_we   <= req_we_i;
            cap_err  <= addr_err;
            cap_uns  <= req_unsigned_i;
            cap_size <= req_size_i;
            cap_off  <= req_addr_i[1:0];
            if (req_we_i && !addr_err) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

    assign sel_byte = cap_word[8*cap_off +: 8];
    assign sel_half = cap_off[1] ? cap_word[31:16] : cap_word[15:0];

    always_comb begin
        resp_rdata_o = 32'd0;
        if (state == RESP && !cap_we && !cap_err) begin
            case (cap_size)
                2'b00:   resp_rdata_o = {{24{sel_byte[7] & ~cap_uns}}, sel_byte};
                2'b01:   resp_rdata_o = {{16{sel_half[15] & ~cap_uns}}, sel_half};
                2'b10:   resp_rdata_o = cap_word;
                default: resp_rdata_o = 32'd0;
            endcase
        end
    end

    assign resp_valid_o = (state == RESP);
    assign resp_err_o   = (state == RESP) && cap_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=1 instance for data paths and
// a LATENCY=3 instance for back-pressure and mid-operation reset.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, v1, we1, un1, rdy1, rv1, er1, st1;
    logic [31:0] addr1, wd1, rd1;
    logic [1:0]  sz1;
    logic        rst3, v3, we3, un3, rdy3, rv3, er3, st3;
    logic [31:0] addr3, wd3, rd3;
    logic [1:0]  sz3;

    dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst1), .req_valid_i(v1), .req_ready_o(rdy1), .req_we_i(we1),
        .req_addr_i(addr1), .req_wdata_i(wd1), .req_size_i(sz1), .req_unsigned_i(un1),
        .resp_valid_o(rv1), .resp_rdata_o(rd1), .resp_err_o(er1), .stall_o(st1)
    );

    dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst3), .req_valid_i(v3), .req_ready_o(rdy3), .req_we_i(we3),
        .req_addr_i(addr3), .req_wdata_i(wd3), .req_size_i(sz3), .req_unsigned_i(un3),
        .resp_valid_o(rv3), .resp_rdata_o(rd3), .resp_err_o(er3), .stall_o(st3)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one request at a negedge and wait (bounded) for its response.
    task automatic do_req(input bit l3, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                          output logic [31:0] rdata, output logic err, output int lat);
        if (l3) begin
            v3 = 1'b1; we3 = we; addr3 = addr; wd3 = wdata; sz3 = size; un3 = uns;
        end else begin
            v1 = 1'b1; we1 = we; addr1 = addr; wd1 = wdata; sz1 = size; un1 = uns;
            #1 check("stall1_never", {31'd0, st1}, 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        if (l3) v3 = 1'b0; else v1 = 1'b0;
        lat = 1;
        while (!(l3 ? rv3 : rv1) && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rdata = l3 ? rd3 : rd1;
        err   = l3 ? er3 : er1;
    endtask

    task automatic req_chk(input bit l3, input string tag, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input bit uns,
                           input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(l3, we, addr, wdata, size, uns, rd, er, lat);
        check({tag, "_lat"},   lat, exp_lat);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"},   {31'd0, er}, {31'd0, exp_err});
    endtask

    // Accept a request on dut3, then assert reset while it is pending.
    task automatic start_and_reset3(input string tag, input bit we, input logic [31:0] addr,
                                    input logic [31:0] wdata);
        v3 = 1'b1; we3 = we; addr3 = addr; wd3 = wdata; sz3 = 2'b10; un3 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        v3 = 1'b0; rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        check({tag, "_ready_t2"}, {31'd0, rdy3}, 32'd1);
        check({tag, "_novalid_t2"}, {31'd0, rv3}, 32'd0);
        @(negedge clk);
        check({tag, "_novalid_t3"}, {31'd0, rv3}, 32'd0);
        @(negedge clk);
        check({tag, "_novalid_t4"}, {31'd0, rv3}, 32'd0);
    endtask

    initial begin
        rst1 = 1'b1; v1 = 1'b0; we1 = 1'b0; addr1 = '0; wd1 = '0; sz1 = 2'b10; un1 = 1'b0;
        rst3 = 1'b1; v3 = 1'b0; we3 = 1'b0; addr3 = '0; wd3 = '0; sz3 = 2'b10; un3 = 1'b0;
        repeat (3) @(negedge clk);
        rst1 = 1'b0; rst3 = 1'b0;

        check("rst_ready1", {31'd0, rdy1}, 32'd1);
        check("rst_valid1", {31'd0, rv1}, 32'd0);
        check("rst_rdata1", rd1, 32'd0);
        check("rst_err1",   {31'd0, er1}, 32'd0);
        check("rst_ready3", {31'd0, rdy3}, 32'd1);
        check("rst_valid3", {31'd0, rv3}, 32'd0);

        // LATENCY=1, back-to-back store then load of the same word
        req_chk(0, "sw100", 1, 32'h100, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0, 1);
        req_chk(0, "lw100", 0, 32'h100, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0, 1);
        @(negedge clk);
        check("valid_drops", {31'd0, rv1}, 32'd0);

        // Byte/half loads on word 0x80223344 built by sw + sb
        req_chk(0, "sw200",  1, 32'h200, 32'h11223344, 2'b10, 0, 32'h0, 0, 1);
        req_chk(0, "sb203",  1, 32'h203, 32'h00000080, 2'b00, 0, 32'h0, 0, 1);
        req_chk(0, "lb203",  0, 32'h203, 32'h0, 2'b00, 0, 32'hFFFFFF80, 0, 1);
        req_chk(0, "lbu203", 0, 32'h203, 32'h0, 2'b00, 1, 32'h00000080, 0, 1);
        req_chk(0, "lw200",  0, 32'h200, 32'h0, 2'b10, 0, 32'h80223344, 0, 1);
        req_chk(0, "lb201",  0, 32'h201, 32'h0, 2'b00, 0, 32'h00000033, 0, 1);
        req_chk(0, "lh202",  0, 32'h202, 32'h0, 2'b01, 0, 32'hFFFF8022, 0, 1);
        req_chk(0, "lhu202", 0, 32'h202, 32'h0, 2'b01, 1, 32'h00008022, 0, 1);
        req_chk(0, "sh200",  1, 32'h200, 32'h0000ABCD, 2'b01, 0, 32'h0, 0, 1);
        req_chk(0, "lw200b", 0, 32'h200, 32'h0, 2'b10, 0, 32'h8022ABCD, 0, 1);

        // Misalignment / illegal size
        req_chk(0, "lw102_err",  0, 32'h102, 32'h0, 2'b10, 0, 32'h0, 1, 1);
        req_chk(0, "sh101_err",  1, 32'h101, 32'h00001234, 2'b01, 0, 32'h0, 1, 1);
        req_chk(0, "lw100_keep", 0, 32'h100, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0, 1);
        req_chk(0, "sz11_err",   0, 32'h100, 32'h0, 2'b11, 0, 32'h0, 1, 1);

        // Index wrap modulo DEPTH_WORDS
        req_chk(0, "sw4000", 1, 32'h4000, 32'hA5A5A5A5, 2'b10, 0, 32'h0, 0, 1);
        req_chk(0, "lw0",    0, 32'h0,    32'h0, 2'b10, 0, 32'hA5A5A5A5, 0, 1);

        // LATENCY=3 setup
        req_chk(1, "sw10_l3", 1, 32'h10, 32'hCAFEF00D, 2'b10, 0, 32'h0, 0, 3);
        req_chk(1, "sw14_l3", 1, 32'h14, 32'h12345678, 2'b10, 0, 32'h0, 0, 3);

        // Two back-to-back loads with valid held; the address change while busy is ignored
        v3 = 1'b1; we3 = 1'b0; addr3 = 32'h10; sz3 = 2'b10; un3 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        addr3 = 32'h14;
        check("b2b_t1_ready", {31'd0, rdy3}, 32'd0);
        check("b2b_t1_stall", {31'd0, st3}, 32'd1);
        check("b2b_t1_valid", {31'd0, rv3}, 32'd0);
        @(negedge clk);
        check("b2b_t2_ready", {31'd0, rdy3}, 32'd0);
        check("b2b_t2_stall", {31'd0, st3}, 32'd1);
        @(negedge clk);
        check("b2b_t3_valid", {31'd0, rv3}, 32'd1);
        check("b2b_t3_rdata", rd3, 32'hCAFEF00D);
        check("b2b_t3_ready", {31'd0, rdy3}, 32'd1);
        check("b2b_t3_stall", {31'd0, st3}, 32'd0);
        @(negedge clk);
        v3 = 1'b0;
        check("b2b_t4_valid", {31'd0, rv3}, 32'd0);
        check("b2b_t4_ready", {31'd0, rdy3}, 32'd0);
        @(negedge clk);
        check("b2b_t5_valid", {31'd0, rv3}, 32'd0);
        @(negedge clk);
        check("b2b_t6_valid", {31'd0, rv3}, 32'd1);
        check("b2b_t6_rdata", rd3, 32'h12345678);
        @(negedge clk);
        check("b2b_t7_valid", {31'd0, rv3}, 32'd0);
        check("b2b_t7_ready", {31'd0, rdy3}, 32'd1);

        // Reset while a load and then a store are pending
        start_and_reset3("rst_lw", 0, 32'h10, 32'h0);
        start_and_reset3("rst_sw", 1, 32'h24, 32'h00000077);
        req_chk(1, "lw24_after_rst", 0, 32'h24, 32'h0, 2'b10, 0, 32'h00000077, 0, 3);
        req_chk(1, "lw10_after_rst", 0, 32'h10, 32'h0, 2'b10, 0, 32'hCAFEF00D, 0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
